// File: rtl/scanline_irq_unit.sv
// MMC3-style scanline IRQ generator. It filters PPU A12 rising edges, counts them
// down against a CPU-programmed latch and drives the cartridge's active-low IRQ.
module scanline_irq_unit #(
    parameter int A12_LOW_MIN = 3,
    parameter bit ALT_IRQ     = 1'b0
) (
    input  logic        m2,
    input  logic        reset,
    input  logic        mapper_en,
    input  logic        romsel,
    input  logic        cpu_rw_in,
    input  logic [14:0] cpu_addr_in,
    input  logic [7:0]  cpu_data_in,
    input  logic        ppu_a12,
    output logic        irq,
    output logic        irq_pending,
    output logic [7:0]  irq_counter
);

    localparam logic [3:0] LOW_MIN = 4'(A12_LOW_MIN);

    // Register select within $C000-$FFFF, indexed by {A13, A0}.
    typedef enum logic [1:0] {
        REG_LATCH   = 2'b00,
        REG_RELOAD  = 2'b01,
        REG_DISABLE = 2'b10,
        REG_ENABLE  = 2'b11
    } irq_reg_e;

    logic [7:0] r_latch;
    logic [7:0] r_counter;
    logic       r_reload;
    logic       r_enabled;
    logic       r_pending;
    logic       r_irq_n;
    logic       r_sync1;
    logic       r_sync2;
    logic       r_a12_prev;
    logic [3:0] r_low_cnt;

    logic       w_wr;
    irq_reg_e   w_reg_sel;
    logic       w_clk_ev;
    logic       w_nz;
    logic [7:0] w_latch_nxt;
    logic [7:0] w_counter_nxt;
    logic       w_reload_nxt;
    logic       w_enabled_nxt;
    logic       w_pending_nxt;
    logic       w_unused_addr;

    // A12..A1 select other mapper registers and are not decoded here.
    assign w_unused_addr = ^cpu_addr_in[12:1];

    assign w_wr      = mapper_en & ~romsel & ~cpu_rw_in & cpu_addr_in[14];
    assign w_reg_sel = irq_reg_e'({cpu_addr_in[13], cpu_addr_in[0]});
    assign w_clk_ev  = r_sync2 & ~r_a12_prev & (r_low_cnt >= LOW_MIN);

    // The A12 event is resolved first from pre-edge state; CPU writes then
    // override it, so an ack or a $C001 always wins over a same-edge event.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no latch is inferred.
        w_latch_nxt   = r_latch;
        w_counter_nxt = r_counter;
        w_reload_nxt  = r_reload;
        w_enabled_nxt = r_enabled;
        w_pending_nxt = r_pending;
        w_nz          = 1'b0;

        if (w_clk_ev) begin
            if (r_counter == 8'd0 || r_reload) begin
                w_counter_nxt = r_latch;
                w_reload_nxt  = 1'b0;
            end else begin
                w_counter_nxt = r_counter - 8'd1;
            end
            w_nz = (w_counter_nxt == 8'd0) && (!ALT_IRQ || r_counter != 8'd0 || r_reload);
            if (w_nz && r_enabled) begin
                w_pending_nxt = 1'b1;
            end
        end

        if (w_wr) begin
            case (w_reg_sel)
                REG_LATCH:   w_latch_nxt = cpu_data_in;
                REG_RELOAD: begin
                    w_counter_nxt = 8'd0;
                    w_reload_nxt  = 1'b1;
                end
                REG_DISABLE: begin
                    w_enabled_nxt = 1'b0;
                    w_pending_nxt = 1'b0;
                end
                REG_ENABLE:  w_enabled_nxt = 1'b1;
                default:     w_enabled_nxt = r_enabled;
            endcase
        end

        if (!mapper_en) begin
            w_pending_nxt = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge m2) begin
        if (reset) begin
            r_latch    <= '0;
            r_counter  <= '0;
            r_reload   <= 1'b0;
            r_enabled  <= 1'b0;
            r_pending  <= 1'b0;
            r_irq_n    <= 1'b1;
            r_sync1    <= 1'b0;
            r_sync2    <= 1'b0;
            r_a12_prev <= 1'b0;
            r_low_cnt  <= '0;
        end else begin
            r_latch    <= w_latch_nxt;
            r_counter  <= w_counter_nxt;
            r_reload   <= w_reload_nxt;
            r_enabled  <= w_enabled_nxt;
            r_pending  <= w_pending_nxt;
            r_irq_n    <= ~w_pending_nxt;
            r_sync1    <= ppu_a12;
            r_sync2    <= r_sync1;
            r_a12_prev <= r_sync2;
            if (r_sync2) begin
                r_low_cnt <= '0;
            end else if (r_low_cnt < LOW_MIN) begin
                r_low_cnt <= r_low_cnt + 4'd1;
            end
        end
    end

    assign irq         = r_irq_n;
    assign irq_pending = r_pending;
    assign irq_counter = r_counter;

endmodule

// File: doc/scanline_irq_unit.md
Name: scanline_irq_unit

Overview:
- MMC3-style scanline IRQ generator that drives the cartridge `irq` pin for the CoolGirl mapper core.
- It watches PPU A12 (`ppu_addr_in[12]`) for filtered rising edges and counts them down against a CPU-programmed latch.
- It decodes the $C000–$FFFF IRQ register writes itself and asserts an active-low IRQ.
- It sits beside the mapper address logic and feeds the top-level `irq` output directly.

Parameters:
- A12_LOW_MIN, 3: consecutive synchronised-low m2 samples of A12 required before a rising edge counts (range 1–15).
- ALT_IRQ, 0: 0 = rev-B behaviour (IRQ whenever the new counter value is 0); 1 = rev-A behaviour (IRQ only when the old counter was nonzero or the reload flag was set).

Ports:
- m2  input  1  system clock (CPU M2); all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- mapper_en  input  1  block active; when 0, writes are ignored and the IRQ is forced inactive.
- romsel  input  1  active-low $8000–$FFFF select.
- cpu_rw_in  input  1  1 = read, 0 = write.
- cpu_addr_in  input  15  CPU address A14..A0.
- cpu_data_in  input  8  CPU write data, stable at the rising m2 edge.
- ppu_a12  input  1  PPU A12, asynchronous to m2.
- irq  output  1  active-low IRQ to the console.
- irq_pending  output  1  active-high pending flag, for debug and status.
- irq_counter  output  8  current counter value, for debug.

Behaviour:
- Reset (sampled at the m2 edge) clears all state:
  - latch = 0, counter = 0, reload = 0, enabled = 0, pending = 0.
  - sync1 = sync2 = a12_prev = 0, low_cnt = 0.
  - Outputs: irq = 1, irq_pending = 0, irq_counter = 0.
  - Reset overrides any simultaneous write or A12 event.
- Write strobe `wr` = mapper_en & ~romsel & ~cpu_rw_in, sampled at each rising m2 edge. Decode:
  - A14=1, A13=0, A0=0 ($C000): latch <= data.
  - A14=1, A13=0, A0=1 ($C001): counter <= 0, reload <= 1.
  - A14=1, A13=1, A0=0 ($E000): enabled <= 0, pending <= 0.
  - A14=1, A13=1, A0=1 ($E001): enabled <= 1.
  - A14=0: ignored (belongs to other mapper registers).
- A12 synchroniser: sync1 <= ppu_a12; sync2 <= sync1; a12_prev <= sync2.
- Low counter: low_cnt <= 0 when sync2 = 1; otherwise it increments, saturating at A12_LOW_MIN.
- Clock event `clk_ev` = sync2 & ~a12_prev & (low_cnt >= A12_LOW_MIN), evaluated combinationally from pre-edge state.
  - If A12 rises just before edge k, sync2 = 1 after edge k+1, so the event is applied at edge k+2.
  - A12 high pulses or low gaps shorter than the filter produce no event.
- On clk_ev:
  - If counter == 0 or reload = 1: counter <= latch, reload <= 0. Otherwise counter <= counter − 1 (8-bit, never wraps below 0 because 0 triggers a reload).
  - `nz` = new counter value == 0. With ALT_IRQ = 1, additionally require (old counter != 0 or reload = 1).
  - If nz and enabled (pre-edge value): pending <= 1.
- Simultaneous events in one m2 cycle:
  - $C001 + clk_ev: clk_ev uses the old counter/reload, then the $C001 effect is applied last (counter = 0, reload = 1).
  - $E000 + clk_ev that would set pending: pending ends 0 (ack wins); the counter update still happens.
  - $E001 + clk_ev with nz: uses pre-edge enabled, so pending stays 0 if the block was disabled.
  - $C000 + clk_ev reload: the reload uses the old latch.
- latch = 0 behaviour:
  - Rev-B: every event reloads 0 and sets pending when enabled.
  - Rev-A: only the first event after $C001 sets pending.
- mapper_en = 0:
  - pending is forced to 0 each edge and writes are ignored.
  - The counter and A12 filter keep running, so re-enabling needs no resync.
- Output mapping: irq = ~pending; irq_pending = pending; irq_counter = counter. All three are registered with no combinational path from the inputs.

Test Plan:
1. Reset, write $C000 = 3, $C001, $E001, then 5 filtered A12 pulses (each 4 m2 low, 4 high) -> counter 3, 2, 1, 0. irq falls at the edge applying the 4th event, exactly 2 edges after the first high sample.
2. With pending set, write $E000 -> irq = 1 next edge and enabled = 0. Further events decrement/reload the counter, but irq stays 1 until $E001 is written and the counter reaches 0 again.
3. A12 pulses with a 2-m2 low gap (A12_LOW_MIN = 3) -> no counter change. A 3-m2 gap -> counted.
4. latch = 0, enabled, 3 events: ALT_IRQ = 0 -> pending set after each event, re-acked by $E000 between events. ALT_IRQ = 1 -> pending only after the first event following $C001.
5. Same-edge collisions:
   - $E000 with a nz event -> pending 0.
   - $C001 with an event from counter 5 -> counter 0 and reload 1 after the edge; the next event loads the latch.
6. Assert reset mid-count (counter 7, pending 1) -> the next edge gives all state 0 and irq = 1. With mapper_en = 0, $E001 is ignored and irq stays 1.
